// File: rtl/piso_serializer_if.sv
// Handshake and serial-link bundle for piso_serializer.
//   par_in     : parallel word offered by upstream
//   par_valid  : upstream has a word on par_in
//   par_ready  : serializer can accept a word this cycle
//   ser_out    : serial data bit (feeds sipo data_in)
//   ser_en     : ser_out carries a valid bit (feeds sipo load/shift-enable)
//   frame_done : one-cycle pulse with the last bit of a frame
// Modports: master = upstream/downstream environment, slave = serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] par_in;
  logic             par_valid;
  logic             par_ready;
  logic             ser_out;
  logic             ser_en;
  logic             frame_done;

  modport master (
    output par_in,
    output par_valid,
    input  par_ready,
    input  ser_out,
    input  ser_en,
    input  frame_done
  );

  modport slave (
    input  par_in,
    input  par_valid,
    output par_ready,
    output ser_out,
    output ser_en,
    output frame_done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer.
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit per clock on ser_out with ser_en high, pulsing frame_done on the last
// bit. After each frame GAP idle cycles (ser_en=0, par_ready=0) are inserted
// before the next word can be accepted.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : piso_serializer_if slave modport (par_in, par_valid, par_ready,
//          ser_out, ser_en, frame_done); all outputs are registered
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input  logic            clk,
  input  logic            rst,
  piso_serializer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  // A zero-width gap counter is not legal; GAP=0 never enters ST_GAP anyway.
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             ready_q;
  logic             ser_out_q;
  logic             ser_en_q;
  logic             done_q;

  // Bit that leaves the shift register next, and the register after it leaves.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  // bit_cnt holds (SHIFT cycle number - 1): the first bit is presented on
  // ser_out straight from the accept edge, so each SHIFT edge emits the
  // following bit and frame_done is raised together with bit WIDTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ready_q   <= 1'b1;
      ser_out_q <= 1'b0;
      ser_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ser_en_q  <= 1'b0;
          ser_out_q <= 1'b0;
          done_q    <= 1'b0;
          ready_q   <= 1'b1;
          if (bus.par_valid && ready_q) begin
            state     <= ST_SHIFT;
            shreg     <= advance(bus.par_in);
            bit_cnt   <= '0;
            ready_q   <= 1'b0;
            ser_en_q  <= 1'b1;
            ser_out_q <= head_bit(bus.par_in);
            done_q    <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (bit_cnt == CW'(WIDTH - 1)) begin
            ser_en_q  <= 1'b0;
            ser_out_q <= 1'b0;
            done_q    <= 1'b0;
            if (GAP > 0) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            shreg     <= advance(shreg);
            ser_out_q <= head_bit(shreg);
            done_q    <= (bit_cnt == CW'(WIDTH - 2));
          end
        end

        ST_GAP: begin
          ser_en_q  <= 1'b0;
          ser_out_q <= 1'b0;
          done_q    <= 1'b0;
          if (gap_cnt == GW'(GAP - 1)) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          ready_q   <= 1'b1;
          ser_en_q  <= 1'b0;
          ser_out_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.par_ready  = ready_q;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_en     = ser_en_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (MSB-first/GAP=0,
// LSB-first/GAP=0, MSB-first/GAP=2) share clk/rst; sel chooses which one the
// stimulus drives and whose outputs are checked.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic       valid;
  logic [3:0] din;

  int unsigned n_checks;
  int unsigned n_fail;

  piso_serializer_if #(.WIDTH(4)) if0 ();
  piso_serializer_if #(.WIDTH(4)) if1 ();
  piso_serializer_if #(.WIDTH(4)) if2 ();

  assign if0.par_valid = valid && (sel == 2'd0);
  assign if1.par_valid = valid && (sel == 2'd1);
  assign if2.par_valid = valid && (sel == 2'd2);
  assign if0.par_in    = din;
  assign if1.par_in    = din;
  assign if2.par_in    = din;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  logic m_ready, m_out, m_en, m_done;

  always_comb begin
    m_ready = if0.par_ready;
    m_out   = if0.ser_out;
    m_en    = if0.ser_en;
    m_done  = if0.frame_done;
    case (sel)
      2'd1: begin
        m_ready = if1.par_ready;
        m_out   = if1.ser_out;
        m_en    = if1.ser_en;
        m_done  = if1.frame_done;
      end
      2'd2: begin
        m_ready = if2.par_ready;
        m_out   = if2.ser_out;
        m_en    = if2.ser_en;
        m_done  = if2.frame_done;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Quiet cycle: serial idle with the given par_ready value.
  task automatic check_idle(input string tag, input logic exp_ready);
    check_val({tag, ".en"},    32'(m_en),    32'd0);
    check_val({tag, ".out"},   32'(m_out),   32'd0);
    check_val({tag, ".done"},  32'(m_done),  32'd0);
    check_val({tag, ".ready"}, 32'(m_ready), 32'(exp_ready));
  endtask

  // Called at the negedge of SHIFT cycle 1. exp[3] is the first bit on the
  // wire. In cycle k, after checking, par_valid=vpat[k] and par_in=d are
  // driven. Returns at the negedge of cycle 4.
  task automatic check_frame(input string tag, input logic [3:0] exp,
                             input logic [3:0] vpat, input logic [3:0] d);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("%s.en%0d", tag, k+1),    32'(m_en),    32'd1);
      check_val($sformatf("%s.bit%0d", tag, k+1),   32'(m_out),   32'(exp[3-k]));
      check_val($sformatf("%s.done%0d", tag, k+1),  32'(m_done),  32'(k == 3));
      check_val($sformatf("%s.ready%0d", tag, k+1), 32'(m_ready), 32'd0);
      valid = vpat[k];
      din   = d;
      if (k < 3) @(negedge clk);
    end
  endtask

  // From an idle negedge: offer w for one cycle, check the frame and the
  // following idle cycle with par_ready back high (GAP=0 instances).
  task automatic send_word(input string tag, input logic [3:0] w, input logic [3:0] exp);
    check_val({tag, ".pre_ready"}, 32'(m_ready), 32'd1);
    valid = 1'b1;
    din   = w;
    @(negedge clk);
    valid = 1'b0;
    check_frame(tag, exp, 4'b0000, w);
    @(negedge clk);
    check_idle({tag, ".post"}, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sel      = 2'd0;
    valid    = 1'b0;
    din      = 4'h0;
    rst      = 1'b1;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #0 check_idle($sformatf("reset%0d", s), 1'b1);
    end
    sel = 2'd0;
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset", 1'b1);

    // MSB first, single word
    send_word("msb_A", 4'hA, 4'b1010);

    // LSB first
    sel = 2'd1;
    send_word("lsb_A", 4'hA, 4'b0101);
    send_word("lsb_1", 4'h1, 4'b1000);

    // Back-to-back with par_valid held: one idle cycle between frames,
    // frame_done pulses in cycles 4 and 9.
    sel   = 2'd0;
    valid = 1'b1;
    din   = 4'h3;
    @(negedge clk);
    check_frame("b2b_3", 4'b0011, 4'b1111, 4'hC);
    @(negedge clk);
    check_idle("b2b_gap", 1'b1);
    @(negedge clk);
    valid = 1'b0;
    check_frame("b2b_C", 4'b1100, 4'b0000, 4'hC);
    @(negedge clk);
    check_idle("b2b_end", 1'b1);

    // GAP=2: two cycles with par_ready low, then 4'h5 accepted
    sel   = 2'd2;
    valid = 1'b1;
    din   = 4'hF;
    @(negedge clk);
    check_frame("gap_F", 4'b1111, 4'b1111, 4'h5);
    @(negedge clk);
    check_idle("gap_c1", 1'b0);
    @(negedge clk);
    check_idle("gap_c2", 1'b0);
    @(negedge clk);
    check_idle("gap_c3", 1'b1);
    @(negedge clk);
    valid = 1'b0;
    check_frame("gap_5", 4'b0101, 4'b0000, 4'h5);
    repeat (3) @(negedge clk);
    check_idle("gap_end", 1'b1);

    // par_valid toggling and par_in changing mid-frame
    sel   = 2'd0;
    valid = 1'b1;
    din   = 4'h9;
    @(negedge clk);
    check_frame("tog_9", 4'b1001, 4'b1010, 4'h6);
    @(negedge clk);
    check_idle("tog_gap", 1'b1);
    @(negedge clk);
    valid = 1'b0;
    check_frame("tog_6", 4'b0110, 4'b0000, 4'h6);
    @(negedge clk);
    check_idle("tog_end", 1'b1);

    // Reset after two bits of 4'hA
    valid = 1'b1;
    din   = 4'hA;
    @(negedge clk);
    valid = 1'b0;
    check_val("rst_bit1", 32'(m_out), 32'd1);
    @(negedge clk);
    check_val("rst_bit2", 32'(m_out), 32'd0);
    check_val("rst_en2",  32'(m_en),  32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle("rst_async", 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_idle($sformatf("rst_after%0d", c), 1'b1);
    end
    send_word("rst_3", 4'h3, 4'b0011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out serializer that sits directly upstream of the team's sipo deserializer. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock. Its ser_out drives the sipo's data_in and its ser_en drives the sipo's load/shift-enable. An optional idle gap is inserted between frames.

Parameters:
WIDTH, 4, word width in bits (>=2)
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
GAP, 0, idle cycles with ser_en=0 inserted after each frame before accepting the next word (>=0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
par_in  input  WIDTH  parallel word, sampled only on accept
par_valid  input  1  upstream has a word on par_in
par_ready  output  1  block can accept a word this cycle
ser_out  output  1  serial data bit
ser_en  output  1  high while ser_out carries a valid bit (drives downstream load)
frame_done  output  1  one-cycle pulse coincident with the last bit of a frame

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high: clk, rst.
- Reset values: par_ready=1, ser_out=0, ser_en=0, frame_done=0. State is IDLE. Shift register and counters are 0.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - par_ready=1, ser_en=0, ser_out=0.
  - Accept occurs at the clk edge where par_valid=1 and par_ready=1: load shift register from par_in, bit counter=0, go to SHIFT.
  - par_ready=0 from the next cycle.
- SHIFT:
  - Lasts exactly WIDTH cycles, numbered 1..WIDTH after the accept edge.
  - ser_en=1 in each of these cycles. ser_out carries bit k of the captured word:
    - MSB_FIRST=1: order WIDTH-1 down to 0.
    - MSB_FIRST=0: order 0 up to WIDTH-1.
  - frame_done=1 only in cycle WIDTH.
  - After cycle WIDTH: go to GAP if GAP>0, else go to IDLE.
- GAP:
  - ser_en=0, ser_out=0, par_ready=0 for exactly GAP cycles, then go to IDLE.
- Throughput:
  - par_ready rises in cycle WIDTH+GAP+1.
  - Minimum period per word is WIDTH+GAP+1 cycles.
  - Back-to-back words therefore have at least one ser_en=0 cycle between frames.
- par_valid while par_ready=0: ignored. par_in is not sampled. No word is lost or duplicated; upstream must hold par_valid until accepted.
- par_in changing during SHIFT: no effect on the frame in flight.
- par_valid deasserting after accept: no effect.
- rst asserted mid-frame: the frame is aborted immediately (asynchronously). Outputs take reset values and no frame_done is produced. After rst deasserts, the block is in IDLE with par_ready=1.
- Counter width is $clog2(WIDTH+1), with a separate $clog2(GAP+1) gap counter. There is no wrap-around beyond WIDTH or GAP.

Test Plan:
- WIDTH=4, MSB_FIRST=1, GAP=0. Release rst, then present par_in=4'hA with par_valid=1 for one cycle.
  -> ser_en=1 for 4 cycles; ser_out=1,0,1,0; frame_done high only on the 4th bit; par_ready low during the frame and back to 1 the following cycle.
- MSB_FIRST=0, par_in=4'hA.
  -> ser_out=0,1,0,1.
  - Also par_in=4'h1 -> ser_out=1,0,0,0.
- Hold par_valid=1 continuously, with par_in=4'h3 then 4'hC, GAP=0.
  -> ser_out=0,0,1,1, then exactly one cycle with ser_en=0, then 1,1,0,0.
  -> Two frame_done pulses, spaced 5 cycles apart.
- GAP=2: accept 4'hF, then offer 4'h5 immediately.
  -> After the 4 bits of 4'hF, ser_en=0 and par_ready=0 for 2 cycles; par_ready=1 in the 3rd cycle; 4'h5 is then sent as 0,1,0,1.
- During SHIFT of 4'h9, toggle par_valid and set par_in=4'h6.
  -> Output remains 1,0,0,1. 4'h6 is accepted only once par_ready=1 and is then sent as 0,1,1,0.
- Assert rst after 2 bits of 4'hA.
  -> ser_en, ser_out and frame_done go to 0 immediately and par_ready=1. No frame_done occurs. A new word 4'h3 sent after rst deasserts yields 0,0,1,1.
